// File: rtl/led_share_scheduler.sv
// Round-robin time-sharing of the 8 green LEDs between 4 pattern requesters.
// Optional idle heartbeat on LEDG[0] when LED_HEARTBEAT_EN is defined.
module led_share_scheduler #(
  parameter int unsigned TICK_DIV   = 50000000,
  parameter int unsigned HOLD_TICKS = 2
) (
  input  logic        CLOCK_50,
  input  logic        RST_N,
  input  logic [3:0]  REQ,
  input  logic [31:0] REQ_DATA,
  input  logic [3:0]  REL,
  output logic [3:0]  GNT,
  output logic [7:0]  LEDG,
  output logic        TICK
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam int unsigned HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  state_t        state;
  logic [PW-1:0] presc;
  logic [HW-1:0] hold;
  logic [1:0]    ptr;
  logic [1:0]    gidx;
  logic          first;
  logic [1:0]    winner;
  logic [1:0]    idx;
  logic          found;
  logic          tick_cnt;
  logic          end_cond;
  logic [7:0]    idle_led;

  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      presc <= '0;
      TICK  <= 1'b0;
    end else if (presc == PW'(TICK_DIV - 1)) begin
      presc <= '0;
      TICK  <= 1'b1;
    end else begin
      presc <= presc + 1'b1;
      TICK  <= 1'b0;
    end
  end

  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      idx = ptr + 2'(i);
      if (!found && REQ[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  // A tick visible in the first granted cycle belongs to the previous owner.
  assign tick_cnt = TICK && !first;
  assign end_cond = (tick_cnt && hold == HW'(HOLD_TICKS - 1)) || !REQ[gidx] || REL[gidx];

`ifdef LED_HEARTBEAT_EN
  logic hb;
  logic hb_next;

  assign hb_next  = (state == IDLE && TICK) ? ~hb : hb;
  assign idle_led = {7'b0000000, hb_next};

  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) hb <= 1'b0;
    else        hb <= hb_next;
  end
`else
  assign idle_led = '0;
`endif

  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
      GNT   <= '0;
      LEDG  <= '0;
      ptr   <= '0;
      hold  <= '0;
      gidx  <= '0;
      first <= 1'b0;
    end else begin
      case (state)
        IDLE, GAP: begin
          if (found) begin
            state <= GRANT;
            GNT   <= 4'b0001 << winner;
            gidx  <= winner;
            ptr   <= winner + 2'd1;
            hold  <= '0;
            first <= 1'b1;
            LEDG  <= '0;
          end else begin
            state <= IDLE;
            GNT   <= '0;
            LEDG  <= idle_led;
          end
        end
        GRANT: begin
          first <= 1'b0;
          if (end_cond) begin
            state <= GAP;
            GNT   <= '0;
            LEDG  <= '0;
          end else begin
            LEDG <= REQ_DATA[{gidx, 3'b000} +: 8];
            if (tick_cnt) hold <= hold + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          GNT   <= '0;
          LEDG  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_share_scheduler.sv
// Directed bench for led_share_scheduler with TICK_DIV=4, HOLD_TICKS=2.
module tb_led_share_scheduler;

  logic        CLOCK_50 = 1'b0;
  logic        RST_N;
  logic [3:0]  REQ;
  logic [31:0] REQ_DATA;
  logic [3:0]  REL;
  logic [3:0]  GNT;
  logic [7:0]  LEDG;
  logic        TICK;

  int unsigned compared   = 0;
  int unsigned mismatched = 0;
  int unsigned nidx       = 0;
  logic [7:0]  hb_on;

  led_share_scheduler #(.TICK_DIV(4), .HOLD_TICKS(2)) dut (
    .CLOCK_50 (CLOCK_50),
    .RST_N    (RST_N),
    .REQ      (REQ),
    .REQ_DATA (REQ_DATA),
    .REL      (REL),
    .GNT      (GNT),
    .LEDG     (LEDG),
    .TICK     (TICK)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to the k-th falling edge after the latest reset release.
  task automatic at(input int unsigned k);
    while (nidx < k) begin
      @(negedge CLOCK_50);
      nidx++;
    end
  endtask

  initial begin
`ifdef LED_HEARTBEAT_EN
    hb_on = 8'h01;
`else
    hb_on = 8'h00;
`endif
    RST_N = 1'b0; REQ = '0; REL = '0; REQ_DATA = '0;
    #12;
    chk("rst_gnt", 32'(GNT), 0);
    chk("rst_ledg", 32'(LEDG), 0);
    chk("rst_tick", 32'(TICK), 0);
    @(negedge CLOCK_50);
    RST_N = 1'b1; nidx = 0;

    // prescaler phase and single requester
    at(1);  chk("tick_n1", 32'(TICK), 0);
    at(3);  chk("tick_n3", 32'(TICK), 0);
    at(4);  chk("tick_first", 32'(TICK), 1);
    at(5);  chk("tick_n5", 32'(TICK), 0);
    REQ = 4'b0001; REQ_DATA = 32'h000000A5;
    at(6);  chk("single_gnt", 32'(GNT), 4'b0001); chk("single_led_lat", 32'(LEDG), 0);
    at(7);  chk("single_led", 32'(LEDG), 8'hA5);
    at(8);  chk("tick_n8", 32'(TICK), 1);
    at(12); chk("single_hold", 32'(GNT), 4'b0001);
    at(13); chk("single_gap_gnt", 32'(GNT), 0); chk("single_gap_led", 32'(LEDG), 0);
    at(14); chk("single_regnt", 32'(GNT), 4'b0001);
    at(15); chk("single_reled", 32'(LEDG), 8'hA5);

    // asynchronous reset mid-grant, while TICK is high
    #7;
    RST_N = 1'b0; REQ = '0; REQ_DATA = '0;
    #1;
    chk("arst_gnt", 32'(GNT), 0);
    chk("arst_ledg", 32'(LEDG), 0);
    chk("arst_tick", 32'(TICK), 0);
    @(negedge CLOCK_50);
    RST_N = 1'b1; nidx = 0;

    // round robin
    at(1);  chk("rr_idle_gnt", 32'(GNT), 0);
    at(3);  chk("rr_tick_n3", 32'(TICK), 0);
    at(4);  chk("rr_tick_n4", 32'(TICK), 1);
    REQ = 4'b1111; REQ_DATA = 32'h08040201;
    at(6);  chk("rr_g0", 32'(GNT), 4'b0001); chk("rr_l0", 32'(LEDG), 8'h01);
    at(12); chk("rr_g0_hold", 32'(GNT), 4'b0001);
    at(13); chk("rr_gap0_gnt", 32'(GNT), 0); chk("rr_gap0_led", 32'(LEDG), 0);
    at(14); chk("rr_g1", 32'(GNT), 4'b0010);
    at(15); chk("rr_l1", 32'(LEDG), 8'h02);
    at(21); chk("rr_gap1_gnt", 32'(GNT), 0); chk("rr_gap1_led", 32'(LEDG), 0);
    at(22); chk("rr_g2", 32'(GNT), 4'b0100);
    at(23); chk("rr_l2", 32'(LEDG), 8'h04);
    at(29); chk("rr_gap2_gnt", 32'(GNT), 0);
    at(30); chk("rr_g3", 32'(GNT), 4'b1000);
    at(31); chk("rr_l3", 32'(LEDG), 8'h08);
    at(37); chk("rr_gap3_gnt", 32'(GNT), 0); chk("rr_gap3_led", 32'(LEDG), 0);
    at(38); chk("rr_g0_again", 32'(GNT), 4'b0001);
    at(39); chk("rr_l0_again", 32'(LEDG), 8'h01);

    // early release; a release from a non-granted requester is ignored
    at(54); chk("rel_g2", 32'(GNT), 4'b0100);
    REL = 4'b0001;
    at(55); chk("rel_other_gnt", 32'(GNT), 4'b0100); chk("rel_l2", 32'(LEDG), 8'h04);
    REL = 4'b0000;
    at(56); chk("rel_other_hold", 32'(GNT), 4'b0100);
    at(58); chk("rel_pre", 32'(GNT), 4'b0100);
    REL = 4'b0100;
    at(59); chk("rel_gap_gnt", 32'(GNT), 0); chk("rel_gap_led", 32'(LEDG), 0);
    REL = 4'b0000;
    at(60); chk("rel_next_g3", 32'(GNT), 4'b1000); chk("rel_entry_tick", 32'(TICK), 1);
    at(61); chk("rel_l3", 32'(LEDG), 8'h08);
    at(65); chk("entry_tick_ignored", 32'(GNT), 4'b1000);
    at(68); chk("g3_hold", 32'(GNT), 4'b1000);
    at(69); chk("g3_expire", 32'(GNT), 0);

    // request drop coinciding with the expiring tick, then idle
    at(70); chk("drop_g0", 32'(GNT), 4'b0001);
    at(84); chk("drop_g1", 32'(GNT), 4'b0010); chk("drop_l1", 32'(LEDG), 8'h02);
    REQ = 4'b1101;
    at(85); chk("drop_gap_gnt", 32'(GNT), 0); chk("drop_gap_led", 32'(LEDG), 0);
    at(86); chk("drop_next_g2", 32'(GNT), 4'b0100);
    at(87); chk("drop_l2", 32'(LEDG), 8'h04);
    REQ = 4'b0000;
    at(88); chk("idle_gap_gnt", 32'(GNT), 0); chk("idle_gap_led", 32'(LEDG), 0);
    at(89); chk("idle_gnt", 32'(GNT), 0); chk("idle_led", 32'(LEDG), 0);
    at(92); chk("idle_led_n92", 32'(LEDG), 0);
    at(93); chk("hb_on_n93", 32'(LEDG), hb_on);
    at(96); chk("hb_on_n96", 32'(LEDG), hb_on);
    at(97); chk("hb_off_n97", 32'(LEDG), 0);
    at(98); chk("idle_tick_off", 32'(TICK), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
